mem_dump_fsm: RTL and testbench

Program-memory readback engine: on a start pulse it reads N 32-bit words from memory and serializes them MSB-first as bytes to the UART transmitter. It is the transmit-side counterpart of the loader path, which assembles UART bytes into instructions. It emits the same framing the loader consumes: one count byte, then 4 bytes per word at byte addresses 0, 4, 8, and so on. It sits between program memory (read port) and the UART TX (tx_start/tx_done handshake) and is used for host-side verification of a loaded program.

---
 rtl/mem_dump_fsm_pkg.sv | 18 +
 rtl/mem_dump_fsm_word_byte_shifter.sv | 20 ++
 rtl/mem_dump_fsm.sv | 118 +++++++++++
 tb/tb_mem_dump_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_fsm_pkg.sv
// mem_dump_fsm_pkg: state encoding and word/byte framing constants shared by the dump and loader FSMs
package mem_dump_fsm_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STEP = 4;
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SEND_COUNT = 4'd1,
        WAIT_COUNT = 4'd2,
        READ_REQ   = 4'd3,
        READ_WAIT  = 4'd4,
        SEND_BYTE  = 4'd5,
        WAIT_TX    = 4'd6,
        NEXT_WORD  = 4'd7,
        SEND_CSUM  = 4'd8,
        WAIT_CSUM  = 4'd9,
        DONE       = 4'd10
    } state_t;
endpackage

// File: rtl/mem_dump_fsm_word_byte_shifter.sv
// word_byte_shifter: holds one memory word and exposes its top byte, shifting left one byte per strobe
module word_byte_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    output logic [BYTE_WIDTH-1:0] top_byte
);
    logic [DATA_WIDTH-1:0] word;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) word <= '0;
        else if (load) word <= load_data;
        else if (shift) word <= word << BYTE_WIDTH;
    end
    assign top_byte = word[DATA_WIDTH-1 -: BYTE_WIDTH];
endmodule

// File: rtl/mem_dump_fsm.sv
// mem_dump_fsm: reads n_words memory words and streams count byte + MSB-first data bytes to the UART TX.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum trailer byte over the data bytes.
module mem_dump_fsm
    import mem_dump_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] n_words,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  dump_done
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam state_t TAIL = SEND_CSUM;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t                state_reg, state_next;
    logic [BYTE_WIDTH-1:0] count_reg, word_idx, top_byte;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [1:0]            byte_idx;
    logic                  last_word, shift;

    assign last_word = (word_idx + BYTE_WIDTH'(1)) == count_reg;
    assign shift = (state_reg == WAIT_TX) && tx_done;

    word_byte_shifter #(.DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)) u_shifter (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (state_reg == READ_WAIT),
        .load_data(rd_data),
        .shift    (shift),
        .top_byte (top_byte)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            word_idx  <= '0;
            addr_reg  <= '0;
            byte_idx  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (start) begin
                    count_reg <= n_words;
                    word_idx  <= '0;
                    addr_reg  <= '0;
                end
                READ_WAIT: byte_idx <= '0;
                WAIT_TX: if (tx_done && byte_idx != LAST_BYTE) byte_idx <= byte_idx + 2'd1;
                NEXT_WORD: begin
                    word_idx <= word_idx + BYTE_WIDTH'(1);
                    addr_reg <= addr_reg + ADDR_WIDTH'(ADDR_STEP);
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] csum_reg;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) csum_reg <= '0;
        else if (state_reg == IDLE && start) csum_reg <= '0;
        else if (shift) csum_reg <= csum_reg ^ top_byte;
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       state_next = start ? SEND_COUNT : IDLE;
            SEND_COUNT: state_next = WAIT_COUNT;
            WAIT_COUNT: if (tx_done) state_next = (count_reg == '0) ? TAIL : READ_REQ;
            READ_REQ:   state_next = READ_WAIT;
            READ_WAIT:  state_next = SEND_BYTE;
            SEND_BYTE:  state_next = WAIT_TX;
            WAIT_TX:    if (tx_done) state_next = (byte_idx == LAST_BYTE) ? NEXT_WORD : SEND_BYTE;
            NEXT_WORD:  state_next = last_word ? TAIL : READ_REQ;
`ifdef MEM_DUMP_CHECKSUM_EN
            SEND_CSUM:  state_next = WAIT_CSUM;
            WAIT_CSUM:  if (tx_done) state_next = DONE;
`endif
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so no input reaches an output combinationally
    always_comb begin
        tx_data = '0;
        if (state_reg inside {SEND_COUNT, WAIT_COUNT}) tx_data = count_reg;
        else if (state_reg inside {SEND_BYTE, WAIT_TX}) tx_data = top_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
        else if (state_reg inside {SEND_CSUM, WAIT_CSUM}) tx_data = csum_reg;
`endif
    end

    assign rd_en     = state_reg == READ_REQ;
    assign rd_addr   = rd_en ? addr_reg : '0;
    assign tx_start  = state_reg inside {SEND_COUNT, SEND_BYTE, SEND_CSUM};
    assign busy      = state_reg != IDLE;
    assign dump_done = state_reg == DONE;
endmodule

// File: tb/tb_mem_dump_fsm.sv
// tb_mem_dump_fsm: scoreboard bench; expected bytes/addresses are queued by stimulus and checked by a monitor
module tb_mem_dump_fsm;
    logic        clk = 0, arst_n = 1, start = 0, tx_done = 0;
    logic [7:0]  n_words = 0;
    logic        rd_en, tx_start, busy, dump_done;
    logic [7:0]  rd_addr, tx_data;
    logic [31:0] rd_data = 0;

    logic [31:0] mem [64];
    logic [7:0]  exp_b [$];
    logic [7:0]  exp_a [$];
    int total = 0, bad = 0, tx_cnt = 0, done_cnt = 0, delay = 0;

    always #5 clk = ~clk;

    mem_dump_fsm dut (
        .clk(clk), .arst_n(arst_n), .start(start), .n_words(n_words),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .busy(busy), .dump_done(dump_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each presented byte / read address with the scoreboard head
    initial forever begin
        @(negedge clk);
        if (arst_n) begin
            if (tx_start) begin
                tx_cnt++;
                if (exp_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected: got byte %0h want none", tx_data);
                end else chk("tx_byte", tx_data, exp_b.pop_front());
            end
            if (rd_en) begin
                if (exp_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got addr %0h want none", rd_addr);
                end else chk("rd_addr", rd_addr, exp_a.pop_front());
            end
            if (dump_done) done_cnt++;
        end
    end

    // Memory: data valid only during the cycle after rd_en
    logic        pv = 0;
    logic [31:0] pw = 0;
    initial forever begin
        @(negedge clk);
        rd_data = pv ? pw : 32'hA5A5_5A5A;
        pv = arst_n && rd_en;
        pw = mem[rd_addr[7:2]];
    end

    // UART TX model: tx_done after 'delay' extra cycles; tx_data must hold meanwhile
    logic       ub = 0;
    logic [7:0] held = 0;
    int         ucnt = 0;
    initial forever begin
        @(negedge clk);
        tx_done = 0;
        if (!arst_n) ub = 0;
        else if (ub) begin
            chk("tx_hold", tx_data, held);
            if (ucnt == 0) begin tx_done = 1; ub = 0; end
            else ucnt--;
        end else if (tx_start) begin
            ub = 1; held = tx_data; ucnt = delay;
        end
    end

    task automatic push_dump(input int n);
        logic [31:0] w;
`ifdef MEM_DUMP_CHECKSUM_EN
        logic [7:0] cs = 0;
`endif
        exp_b.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = mem[i % 64];
            exp_a.push_back(8'(i * 4));
            for (int b = 3; b >= 0; b--) begin
                exp_b.push_back(w[b*8 +: 8]);
`ifdef MEM_DUMP_CHECKSUM_EN
                cs ^= w[b*8 +: 8];
`endif
            end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_b.push_back(cs);
`endif
    endtask

    task automatic do_start(input logic [7:0] n);
        @(negedge clk); n_words = n; start = 1;
        @(negedge clk); start = 0;
        chk("start_to_tx_start", {31'd0, tx_start}, 1);
        chk("busy_after_start", {31'd0, busy}, 1);
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int c = 0;
        while (done_cnt == d0 && c < 20000) begin @(negedge clk); c++; end
        @(negedge clk);
        chk({name, "_done_cnt"}, 32'(done_cnt - d0), 1);
        chk({name, "_busy_clr"}, {31'd0, busy}, 0);
        chk({name, "_bytes_left"}, 32'(exp_b.size()), 0);
        chk({name, "_addrs_left"}, 32'(exp_a.size()), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_en"}, {31'd0, rd_en}, 0);
        chk({name, "_rd_addr"}, {24'd0, rd_addr}, 0);
        chk({name, "_tx_data"}, {24'd0, tx_data}, 0);
        chk({name, "_tx_start"}, {31'd0, tx_start}, 0);
        chk({name, "_busy"}, {31'd0, busy}, 0);
        chk({name, "_dump_done"}, {31'd0, dump_done}, 0);
    endtask

    initial begin
        int base, c, d0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h01234567;
        #1 arst_n = 0;
        #11 chk_zero("reset");
        @(negedge clk); arst_n = 1;

        // two words, hand-computed bytes
        exp_b = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_b.push_back(8'h22);
`endif
        exp_a = '{8'h00, 8'h04};
        do_start(8'd2);
        wait_done("two_words");

        // zero words: count byte only, no reads
        exp_b = '{8'h00};
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_b.push_back(8'h00);
`endif
        do_start(8'd0);
        wait_done("zero_words");

        // one word 0x11223344 (checksum trailer 0x44 when enabled)
        mem[0] = 32'h11223344;
        exp_b = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_b.push_back(8'h44);
`endif
        exp_a = '{8'h00};
        do_start(8'd1);
        wait_done("one_word");

        // slow UART plus an ignored start mid-dump
        mem[0] = 32'hDEADBEEF;
        delay = 100;
        push_dump(2);
        do_start(8'd2);
        repeat (150) @(negedge clk);
        n_words = 8'd5; start = 1;
        @(negedge clk); start = 0;
        chk("busy_mid_dump", {31'd0, busy}, 1);
        wait_done("slow_tx");
        delay = 0;

        // async reset during the second data byte
        push_dump(2);
        base = tx_cnt;
        d0 = done_cnt;
        do_start(8'd2);
        c = 0;
        while (tx_cnt < base + 3 && c < 2000) begin @(negedge clk); c++; end
        chk("reach_second_byte", 32'(tx_cnt - base), 3);
        #2 arst_n = 0;
        #1 chk_zero("mid_reset");
        exp_b.delete();
        exp_a.delete();
        repeat (3) @(negedge clk);
        chk("no_done_on_reset", 32'(done_cnt - d0), 0);
        #2 arst_n = 1;
        push_dump(1);
        do_start(8'd1);
        wait_done("after_reset");

        // 65 words: address wraps to 0x00 on the last word
        for (int i = 0; i < 64; i++) mem[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h55, 8'(i + 7)};
        push_dump(65);
        base = tx_cnt;
        do_start(8'd65);
        wait_done("wrap65");
`ifdef MEM_DUMP_CHECKSUM_EN
        chk("wrap65_byte_count", 32'(tx_cnt - base), 262);
`else
        chk("wrap65_byte_count", 32'(tx_cnt - base), 261);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
